// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pkg
//  Description : Shared types and constants for the multi-channel interrupt
//                controller (handler-nesting state, default cause base).
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    // Handler nesting state: idle, serving an interrupt, serving an
    // exception, or serving an exception raised inside an interrupt handler.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IRQ     = 2'd1,
        EXC     = 2'd2,
        IRQ_EXC = 2'd3
    } irq_state_e;

    // Cause code reported for channel 0; channel k reports this plus k.
    localparam logic [31:0] C_CAUSE_BASE_DEFAULT = 32'h1000_0010;

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : irq_prio_enc
//  Description : Fixed-priority encoder. The lowest set bit of the eligible
//                vector wins; returns valid flag, binary index and one-hot.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  elig_i,
    output logic          valid_o,
    output logic [IW-1:0] index_o,
    output logic [N-1:0]  onehot_o
);

    localparam logic [N-1:0] C_ONE = N'(1);

    // Scan from the top down so the lowest eligible index is the last write.
    always_comb begin
        index_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig_i[i]) begin
                index_o = i[IW-1:0];
            end
        end
        // Two's-complement trick isolates the lowest set bit.
        onehot_o = elig_i & (~elig_i + C_ONE);
        valid_o  = |elig_i;
    end

endmodule : irq_prio_enc
`default_nettype wire

// File: rtl/irq_controller_mc.sv
`default_nettype none
// ============================================================================
//  Module      : irq_controller_mc
//  Description : Multi-channel interrupt controller. Level/edge sensitive
//                channels with per-channel mask, fixed priority (lowest index
//                wins), exception/interrupt nesting tracking, one-hot ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_controller_mc
    import irq_pkg::*;
#(
    parameter int              N_IRQ      = 16,
    parameter logic [N_IRQ-1:0] EDGE_MASK = '0,
    parameter logic [31:0]     CAUSE_BASE = C_CAUSE_BASE_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             exception_i,
    input  logic [N_IRQ-1:0] irq_req_i,
    input  logic [N_IRQ-1:0] irq_mask_i,
    input  logic             mie_i,
    input  logic             mret_i,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    output logic             irq_ret_o,
    output logic [N_IRQ-1:0] irq_ack_o,
    output logic [N_IRQ-1:0] irq_pend_o
);

    localparam int IW = $clog2(N_IRQ);

    irq_state_e       state_q, state_d;
    logic [N_IRQ-1:0] edge_pend_q, edge_pend_d;
    logic [N_IRQ-1:0] req_prev_q, req_prev_d;
    logic [IW-1:0]    id_q, id_d;

    logic [N_IRQ-1:0] pend;
    logic [N_IRQ-1:0] elig;
    logic [N_IRQ-1:0] rise;
    logic             sel_valid;
    logic [IW-1:0]    sel_idx;
    logic [N_IRQ-1:0] sel_onehot;

    irq_prio_enc #(
        .N  (N_IRQ),
        .IW (IW)
    ) u_prio_enc (
        .elig_i   (elig),
        .valid_o  (sel_valid),
        .index_o  (sel_idx),
        .onehot_o (sel_onehot)
    );

    // Pending vector, arbitration, acknowledge and cause selection.
    always_comb begin
        rise        = irq_req_i & ~req_prev_q;
        // Edge channels come from the registered latch, level channels straight from the pins.
        pend        = (EDGE_MASK & edge_pend_q) | (~EDGE_MASK & irq_req_i);
        elig        = pend & irq_mask_i;
        irq_o       = (state_q == IDLE) & mie_i & sel_valid & ~exception_i;
        irq_ack_o   = irq_o ? sel_onehot : '0;
        irq_pend_o  = pend;
        // A fresh rising edge re-arms the latch even if that channel is acked now.
        edge_pend_d = ((edge_pend_q & ~irq_ack_o) | rise) & EDGE_MASK;
        req_prev_d  = irq_req_i;
        id_d        = irq_o ? sel_idx : id_q;
        irq_cause_o = CAUSE_BASE + {{(32 - IW){1'b0}}, (irq_o ? sel_idx : id_q)};
    end

    // Handler nesting FSM; an exception always takes precedence over mret.
    always_comb begin
        state_d   = state_q;
        irq_ret_o = mret_i & (state_q == IRQ) & ~exception_i;
        case (state_q)
            IDLE: begin
                if (exception_i) begin
                    state_d = EXC;
                end else if (irq_o) begin
                    state_d = IRQ;
                end
            end
            IRQ: begin
                if (exception_i) begin
                    state_d = IRQ_EXC;
                end else if (mret_i) begin
                    state_d = IDLE;
                end
            end
            EXC: begin
                if (mret_i && !exception_i) begin
                    state_d = IDLE;
                end
            end
            IRQ_EXC: begin
                if (mret_i && !exception_i) begin
                    state_d = IRQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and pending registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            edge_pend_q <= '0;
            req_prev_q  <= '0;
            id_q        <= '0;
        end else begin
            state_q     <= state_d;
            edge_pend_q <= edge_pend_d;
            req_prev_q  <= req_prev_d;
            id_q        <= id_d;
        end
    end

endmodule : irq_controller_mc
`default_nettype wire
